// File: rtl/rf_writeback.sv
// Write-side front end for the 32x32 register file: arbitrates load/ALU write
// requests into an in-order queue and drains at most one write per cycle.
module rf_writeback #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic [31:0]     ld_data,
  output logic            ld_ready,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [31:0]     alu_data,
  output logic            alu_ready,
  output logic [4:0]      AddrD,
  output logic [31:0]     DataD,
  output logic            RegWEn,
  output logic [31:0]     pending,
  output logic [PTRW:0]   level
);

  localparam logic [PTRW:0] FULL_LVL = (PTRW+1)'(DEPTH);

  logic [36:0]     mem_q [DEPTH];
  logic [PTRW-1:0] wptr_q, wptr_d;
  logic [PTRW-1:0] rptr_q, rptr_d;
  logic [PTRW:0]   level_q, level_d;
  logic [4:0]      addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic            wen_q, wen_d;

  logic            full;
  logic            ld_take, alu_take;
  logic            push, pop;
  logic [4:0]      req_rd;
  logic [31:0]     req_data;
  logic [PTRW-1:0] pend_idx;
  logic [31:0]     pend;

  // Handshake: a request transfers on a posedge where valid && ready; the
  // producer holds rd/data while valid is high and ready is low. Ready is
  // derived from current occupancy only, never from a same-cycle pop.
  always_comb begin
    full      = (level_q == FULL_LVL);
    ld_ready  = !full;
    alu_ready = !full && !ld_valid;
    ld_take   = ld_valid && ld_ready;
    alu_take  = alu_valid && alu_ready;
    req_rd    = ld_take ? ld_rd : alu_rd;
    req_data  = ld_take ? ld_data : alu_data;
    // Writes to x0 complete the handshake but never occupy a slot.
    push      = (ld_take || alu_take) && (req_rd != 5'd0);
    pop       = (level_q != '0);
  end

  always_comb begin
    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    wen_d  = pop;
    addr_d = pop ? mem_q[rptr_q][36:32] : addr_q;
    data_d = pop ? mem_q[rptr_q][31:0]  : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wen_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wen_q   <= wen_d;
    end
  end

  // Queue storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= {req_rd, req_data};
    end
  end

  always_comb begin
    pend     = '0;
    pend_idx = rptr_q;
    for (int k = 0; k < DEPTH; k++) begin
      pend_idx = rptr_q + PTRW'(k);
      if ((PTRW+1)'(k) < level_q) begin
        pend[mem_q[pend_idx][36:32]] = 1'b1;
      end
    end
    if (wen_q) begin
      pend[addr_q] = 1'b1;
    end
    pend[0] = 1'b0;
  end

  assign AddrD   = addr_q;
  assign DataD   = data_q;
  assign RegWEn  = wen_q;
  assign level   = level_q;
  assign pending = pend;

endmodule

// File: tb/tb_rf_writeback.sv
// Bench for rf_writeback: queue-based reference model, scoreboard of expected
// register-file writes, directed scenarios followed by randomized traffic.
module tb_rf_writeback;
  localparam int DEPTH = 4;
  localparam int PTRW  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic            ld_valid = 1'b0;
  logic [4:0]      ld_rd = '0;
  logic [31:0]     ld_data = '0;
  logic            ld_ready;
  logic            alu_valid = 1'b0;
  logic [4:0]      alu_rd = '0;
  logic [31:0]     alu_data = '0;
  logic            alu_ready;
  logic [4:0]      AddrD;
  logic [31:0]     DataD;
  logic            RegWEn;
  logic [31:0]     pending;
  logic [PTRW:0]   level;

  rf_writeback #(.DEPTH(DEPTH), .PTRW(PTRW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .AddrD(AddrD), .DataD(DataD), .RegWEn(RegWEn), .pending(pending), .level(level)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  logic [36:0] mq[$];       // writes still waiting in the queue
  logic [36:0] exp_q[$];    // scoreboard: writes expected on the port, in order
  bit          m_wen = 1'b0;
  logic [4:0]  m_addr = '0;
  bit          m_ld_acc = 1'b0;
  bit          m_alu_acc = 1'b0;

  always @(posedge clk) begin
    logic [36:0] req;
    logic [36:0] head;
    bit full_m;
    if (rst_n) begin
      full_m    = (mq.size() == DEPTH);
      m_ld_acc  = ld_valid && !full_m;
      m_alu_acc = alu_valid && !full_m && !ld_valid;
      if (mq.size() != 0) begin
        head   = mq.pop_front();
        m_wen  = 1'b1;
        m_addr = head[36:32];
      end else begin
        m_wen = 1'b0;
      end
      if (m_ld_acc || m_alu_acc) begin
        req = m_ld_acc ? {ld_rd, ld_data} : {alu_rd, alu_data};
        if (req[36:32] != 5'd0) begin
          mq.push_back(req);
          exp_q.push_back(req);
        end
      end
    end
  end

  function automatic logic [31:0] model_pending();
    logic [31:0] p = '0;
    foreach (mq[i]) p[mq[i][36:32]] = 1'b1;
    if (m_wen) p[m_addr] = 1'b1;
    return p;
  endfunction

  // Per-cycle state checker
  always @(negedge clk) begin
    check("ld_ready", ld_ready, mq.size() != DEPTH);
    check("alu_ready", alu_ready, (mq.size() != DEPTH) && !ld_valid);
    check("level", level, mq.size());
    check("regwen", RegWEn, m_wen);
    check("pending", pending, model_pending());
  end

  // Monitor: every write pulse must match the oldest expected write
  always @(negedge clk) begin
    logic [36:0] e;
    if (RegWEn) begin
      if (exp_q.size() == 0) begin
        fail_now("wr_unexpected");
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", AddrD, e[36:32]);
        check("wr_data", DataD, e[31:0]);
      end
    end
  end

  // ---------------- driver ----------------
  logic [36:0] ld_stim[$];
  logic [36:0] alu_stim[$];
  int gap_pct = 0;

  task automatic run_streams(input int budget);
    int n = 0;
    logic [36:0] e;
    while ((ld_stim.size() > 0 || alu_stim.size() > 0 || ld_valid || alu_valid) && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (ld_valid && m_ld_acc) ld_valid = 1'b0;
      if (alu_valid && m_alu_acc) alu_valid = 1'b0;
      if (!ld_valid && ld_stim.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
        e = ld_stim.pop_front();
        ld_rd = e[36:32]; ld_data = e[31:0]; ld_valid = 1'b1;
      end
      if (!alu_valid && alu_stim.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
        e = alu_stim.pop_front();
        alu_rd = e[36:32]; alu_data = e[31:0]; alu_valid = 1'b1;
      end
    end
    if (n >= budget) fail_now("stream_timeout");
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((mq.size() > 0 || m_wen) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) fail_now("drain_timeout");
    @(negedge clk);
    check({name, "_sb_empty"}, exp_q.size(), 0);
    check({name, "_pending_clear"}, pending, 32'h0);
  endtask

  // Called about 3 time units after a posedge, i.e. between clock edges.
  task automatic async_reset();
    rst_n = 1'b0;
    ld_valid = 1'b0; alu_valid = 1'b0;
    ld_stim.delete(); alu_stim.delete();
    mq.delete(); exp_q.delete();
    m_wen = 1'b0; m_ld_acc = 1'b0; m_alu_acc = 1'b0;
    #1;
    check("rst_regwen", RegWEn, 1'b0);
    check("rst_level", level, 0);
    check("rst_pending", pending, 32'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] rd;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("t1_rst_regwen", RegWEn, 1'b0);
    check("t1_rst_addrd", AddrD, 5'd0);
    check("t1_rst_datad", DataD, 32'h0);
    check("t1_rst_level", level, 0);
    check("t1_rst_pending", pending, 32'h0);
    check("t1_rst_ld_ready", ld_ready, 1'b1);
    check("t1_rst_alu_ready", alu_ready, 1'b1);
    @(posedge clk); #3 rst_n = 1'b1;

    // 1: single write
    ld_stim.push_back({5'd5, 32'hDEADBEEF});
    run_streams(20);
    check("t1_pending5", pending[5], 1'b1);
    drain("t1", 20);

    // 2: priority
    ld_stim.push_back({5'd1, 32'd1});
    alu_stim.push_back({5'd2, 32'd2});
    run_streams(20);
    drain("t2", 20);

    // 3: sustained stream, pointer wrap
    for (int i = 1; i <= 10; i++) ld_stim.push_back({5'(i), 32'(i)});
    run_streams(60);
    drain("t3", 30);

    // 4: x0 filter
    alu_stim.push_back({5'd0, 32'hFFFFFFFF});
    run_streams(20);
    drain("t4", 20);

    // 5: same-register burst
    for (int i = 1; i <= 3; i++) alu_stim.push_back({5'd7, 32'(i)});
    run_streams(20);
    drain("t5", 20);

    // randomized mixed traffic with gaps
    gap_pct = 30;
    for (int i = 0; i < 200; i++) begin
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      if ($urandom_range(0, 1) == 1) ld_stim.push_back({rd, $urandom()});
      else alu_stim.push_back({rd, $urandom()});
    end
    run_streams(3000);
    drain("rand", 50);
    gap_pct = 0;

    // 6: reset mid-operation, then no stale writes
    for (int i = 1; i <= 3; i++) ld_stim.push_back({5'(10 + i), 32'hA000_0000 + 32'(i)});
    run_streams(30);
    #2 async_reset();
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("t6_no_stale_level", level, 0);
    check("t6_no_stale_pending", pending, 32'h0);
    ld_stim.push_back({5'd9, 32'h1234_5678});
    run_streams(20);
    drain("t6", 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    fail_now("watchdog");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
